// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the front end: word size, reset vector,
// bubble instruction and the fetch buffer entry layout.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

    // One decoded-ready slot: the instruction word and the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush, occupancy count and head data.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer advance that wraps for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop   = pop & (count_q != '0) & ~flush;
        do_push  = push & ~flush & ((count_q != CW'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC generation, credit-limited imem requests,
// in-order response buffering and redirect squash of wrong-path fetches.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(2 * DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0] pcq_head;
    logic [OW-1:0]   pcq_count;
    logic [OW-1:0]   buf_count;
    fetch_entry_t    buf_head;
    fetch_entry_t    buf_wdata;

    logic            pop;
    logic [SW-1:0]   occupancy;
    logic            req_ok;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_keep;

    // Outstanding requests (dropped ones included) plus buffered entries never
    // exceed DEPTH, so every response in flight has a slot waiting for it.
    assign id_valid  = (buf_count != '0) & ~redirect_valid;
    assign pop       = id_valid & id_ready;
    assign occupancy = SW'(outstanding_q) + SW'(buf_count) - SW'(pop);
    assign req_ok    = (occupancy < SW'(DEPTH)) & ~redirect_valid;
    assign req_fire  = req_ok & imem_req_ready;

    assign imem_req_valid = req_ok & ~rst;
    assign imem_req_addr  = pc_q;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_fire = imem_rsp_valid & (outstanding_q != '0);
    assign rsp_keep = rsp_fire & (drop_q == '0) & ~redirect_valid & (pcq_count != '0);

    assign buf_wdata = '{pc: pcq_head, instr: imem_rsp_data};

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_fire);
        drop_d        = drop_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d   = align_word(redirect_pc);
            drop_d = outstanding_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (rsp_fire && (drop_q != '0)) begin
                drop_d = drop_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // PCs of live (non-dropped) requests, matched to responses in order.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (rsp_keep),
        .flush (redirect_valid),
        .wdata (pc_q),
        .rdata (pcq_head),
        .count (pcq_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (buf_wdata),
        .rdata (buf_head),
        .count (buf_count)
    );

    assign id_instr = buf_head.instr;
    assign id_pc    = buf_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order latency memory model, a
// behavioural decode-stream model checked every cycle, plus directed literals.
module tb_fetch_unit;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned epoch;
    } mreq_t;

    mreq_t       memq[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned lat      = 1;
    int unsigned epoch    = 0;
    int unsigned pops     = 0;
    int unsigned n_acc    = 0;
    int          buffered = 0;
    logic [31:0] exp_pc      = RST_PC;
    logic [31:0] next_req    = RST_PC;
    logic [31:0] last_pop_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Per-cycle model: the decode stream is the sequential PC stream since the last
    // redirect/reset, each word equal to memory contents; request stream likewise.
    always @(negedge clk) begin
        logic  exp_idv;
        logic  exp_pop;
        logic  exp_req;
        mreq_t e;
        if (rst) begin
            memq.delete();
            buffered = 0;
            exp_pc   = RST_PC;
            next_req = RST_PC;
            n_acc    = 0;
            pops     = 0;
        end else begin
            exp_idv = (buffered > 0) && !redirect_valid;
            exp_pop = exp_idv && id_ready;
            exp_req = ((memq.size() + buffered - int'(exp_pop)) < int'(DEPTH)) && !redirect_valid;
            chk("id_valid", 32'(id_valid), 32'(exp_idv));
            chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
            if (exp_idv) begin
                chk("id_pc", id_pc, exp_pc);
                chk("id_instr", id_instr, mem_word(exp_pc));
            end
            if (exp_req) begin
                chk("req_addr", imem_req_addr, next_req);
            end
            if (imem_rsp_valid && memq.size() > 0) begin
                e = memq.pop_front();
                if (!redirect_valid && e.epoch == epoch) buffered++;
            end
            if (exp_pop) begin
                last_pop_pc = id_pc;
                pops++;
                exp_pc += 32'd4;
                buffered--;
            end
            if (exp_req && imem_req_ready) begin
                memq.push_back('{addr: next_req, due: cyc + lat, epoch: epoch});
                n_acc++;
                next_req += 32'd4;
            end
            if (redirect_valid) begin
                epoch++;
                buffered = 0;
                exp_pc   = redirect_pc & ~32'h3;
                next_req = redirect_pc & ~32'h3;
            end
        end
    end

    task automatic drive_mem();
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic do_reset(input int unsigned l, input logic rdy);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        id_ready       = rdy;
        imem_req_ready = 1'b1;
        lat            = l;
        step();
        step();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        drive_mem();
    endtask

    initial begin
        int unsigned p0;
        logic        found;

        // Streaming with L=1 and decode always ready
        do_reset(1, 1'b1);
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        step();
        step();
        #1;
        chk("first_id_valid", 32'(id_valid), 32'd1);
        chk("first_id_pc", id_pc, 32'h0000_0000);
        chk("first_id_instr", id_instr, 32'h5A00_0013);
        repeat (10) step();
        #1;
        chk("stream_pops", 32'(pops), 32'd10);

        // Redirect coinciding with a response and a decode pop
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        chk("redir_id_valid", 32'(id_valid), 32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("redir_next_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_next_addr", imem_req_addr, 32'h0000_0100);
        chk("redir_buf_empty", 32'(id_valid), 32'd0);
        step();
        step();
        #1;
        chk("redir_first_pc", id_pc, 32'h0000_0100);
        chk("redir_first_instr", id_instr, 32'h5A00_0113);

        // Misaligned redirect target
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("align_addr", imem_req_addr, 32'h0000_0200);

        // PC wrap at the top of the address space
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_first_addr", imem_req_addr, 32'hFFFF_FFFC);
        step();
        #1;
        chk("wrap_valid", 32'(imem_req_valid), 32'd1);
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);
        repeat (4) step();

        // Decode stalled: requests stop at DEPTH, then resume in order
        do_reset(1, 1'b0);
        repeat (10) step();
        #1;
        chk("stall_accepts", 32'(n_acc), 32'(DEPTH));
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_head_pc", id_pc, 32'h0000_0000);
        id_ready = 1'b1;
        #1;
        chk("resume_req_valid", 32'(imem_req_valid), 32'd1);
        chk("resume_addr", imem_req_addr, 32'h0000_0008);
        repeat (6) step();

        // L=3: redirect with 0x10 and 0x14 in flight
        do_reset(3, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (memq.size() == 2 && memq[0].addr == 32'h10 && memq[1].addr == 32'h14) found = 1'b1;
        end
        chk("l3_inflight_reached", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        p0             = pops;
        step();
        redirect_valid = 1'b0;
        found          = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (pops != p0) found = 1'b1;
        end
        chk("l3_pop_seen", 32'(found), 32'd1);
        chk("l3_first_pc", last_pop_pc, 32'h0000_0100);

        // Spurious response with nothing outstanding is ignored
        imem_req_ready = 1'b0;
        repeat (10) step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        step();
        #1;
        chk("spurious_ignored", 32'(id_valid), 32'd0);
        step();
        #1;
        chk("spurious_ignored2", 32'(id_valid), 32'd0);
        imem_req_ready = 1'b1;
        lat            = 1;
        repeat (6) step();

        // Asynchronous reset mid-stream with a full buffer
        id_ready = 1'b0;
        repeat (6) step();
        #2;
        chk("pre_rst_id_valid", 32'(id_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        do_reset(1, 1'b1);
        #1;
        chk("restart_valid", 32'(imem_req_valid), 32'd1);
        chk("restart_addr", imem_req_addr, RST_PC);
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
